// File: rtl/rot_pkg.sv
// Shared definitions for the rotary-count BCD display path.
package rot_pkg;

  localparam int unsigned ROT_CNT_WIDTH  = 32;
  localparam int unsigned ROT_BCD_DIGITS = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bcd_state_t;

endpackage : rot_pkg

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more.
module bcd_add3 (
  input  logic [3:0] din_i,
  output logic [3:0] dout_o
);

  assign dout_o = (din_i >= 4'd5) ? din_i + 4'd3 : din_i;

endmodule : bcd_add3

// File: rtl/rot_count_bcd.sv
// Signed rotary count to sign + packed BCD magnitude, one double-dabble
// step per clock, with a leading-zero blanking mask.
module rot_count_bcd
  import rot_pkg::*;
#(
  parameter int unsigned WIDTH  = ROT_CNT_WIDTH,
  parameter int unsigned DIGITS = ROT_BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      count,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  done,
  output logic                  busy
);

  localparam int unsigned ITER_W = $clog2(WIDTH);
  localparam int unsigned BCD_W  = 4 * DIGITS;

  bcd_state_t          state_q, state_d;
  logic                sign_r_q, sign_r_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_sr_q, bcd_sr_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                sign_q, sign_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic                done_q, done_d;

  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_shift;
  logic [DIGITS-1:0]   en_calc;
  logic                any_nz;

  // Parallel add-3 correction on every digit ahead of the shift
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
    bcd_add3 u_add3 (
      .din_i  (bcd_sr_q[4*g +: 4]),
      .dout_o (bcd_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sign_r_q <= 1'b0;
      bin_q    <= '0;
      bcd_sr_q <= '0;
      iter_q   <= '0;
      bcd_q    <= '0;
      sign_q   <= 1'b0;
      en_q     <= DIGITS'(1);
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_r_q <= sign_r_d;
      bin_q    <= bin_d;
      bcd_sr_q <= bcd_sr_d;
      iter_q   <= iter_d;
      bcd_q    <= bcd_d;
      sign_q   <= sign_d;
      en_q     <= en_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_r_d = sign_r_q;
    bin_d    = bin_q;
    bcd_sr_d = bcd_sr_q;
    iter_d   = iter_q;
    bcd_d    = bcd_q;
    sign_d   = sign_q;
    en_d     = en_q;
    done_d   = 1'b0;
    any_nz   = 1'b0;
    en_calc  = '0;

    bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};

    // A digit is significant if it or any more-significant digit is nonzero
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      any_nz     = any_nz | (|bcd_shift[4*i +: 4]);
      en_calc[i] = any_nz;
    end
    en_calc[0] = 1'b1;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_r_d = count[WIDTH-1];
          bin_d    = count[WIDTH-1] ? WIDTH'(~count + WIDTH'(1)) : count;
          bcd_sr_d = '0;
          iter_d   = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        bcd_sr_d = bcd_shift;
        bin_d    = {bin_q[WIDTH-2:0], 1'b0};
        iter_d   = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(WIDTH - 1)) begin
          bcd_d   = bcd_shift;
          sign_d  = sign_r_q;
          en_d    = en_calc;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == SHIFT);
  assign bcd      = bcd_q;
  assign sign     = sign_q;
  assign digit_en = en_q;
  assign done     = done_q;

endmodule : rot_count_bcd

// File: tb/tb_rot_count_bcd.sv
// Directed bench for rot_count_bcd: vector table plus handshake and reset sequences.
module tb_rot_count_bcd;

  logic        clk;
  logic        reset;
  logic [31:0] count;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] bcd;
  logic        sign;
  logic [9:0]  digit_en;
  logic        done;
  logic        busy;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] cnt;
    logic [39:0] exp_bcd;
    logic        exp_sign;
    logic [9:0]  exp_en;
  } vec_t;

  vec_t vecs[9];

  rot_count_bcd dut (
    .clk      (clk),
    .reset    (reset),
    .count    (count),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bcd      (bcd),
    .sign     (sign),
    .digit_en (digit_en),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference conversion by repeated division, independent of double-dabble
  function automatic logic [39:0] model_bcd(input logic [31:0] c);
    logic [31:0] m;
    logic [39:0] r;
    m = c[31] ? (~c + 32'd1) : c;
    r = '0;
    for (int d = 0; d < 10; d++) begin
      r[4*d +: 4] = 4'(m % 32'd10);
      m = m / 32'd10;
    end
    return r;
  endfunction

  // Accept one value and wait for done; checks latency and in_ready during SHIFT
  task automatic run_conv(input logic [31:0] c, input string tag);
    int lat;
    int rdy_bad;
    lat = -1;
    rdy_bad = 0;
    @(negedge clk);
    chk({tag, "_ready_before"}, 64'(in_ready), 64'd1);
    count = c;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (in_ready !== 1'b0) rdy_bad++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd32);
    chk({tag, "_ready_low_in_shift"}, 64'(rdy_bad), 64'd0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] v;
    int last_acc;
    int accepts;
    int spacing_bad;
    int ready_bad;
    int drained;
    int done_seen;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    count    = '0;

    vecs[0] = '{32'd0,          40'h0000000000, 1'b0, 10'b0000000001};
    vecs[1] = '{32'd12345,      40'h0000012345, 1'b0, 10'b0000011111};
    vecs[2] = '{32'hFFFFFFFF,   40'h0000000001, 1'b1, 10'b0000000001};
    vecs[3] = '{32'h80000000,   40'h2147483648, 1'b1, 10'b1111111111};
    vecs[4] = '{32'h7FFFFFFF,   40'h2147483647, 1'b0, 10'b1111111111};
    vecs[5] = '{-32'sd999,      40'h0000000999, 1'b1, 10'b0000000111};
    vecs[6] = '{32'd1000000000, 40'h1000000000, 1'b0, 10'b1111111111};
    vecs[7] = '{32'd100,        40'h0000000100, 1'b0, 10'b0000000111};
    vecs[8] = '{-32'sd10,       40'h0000000010, 1'b1, 10'b0000000011};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_bcd",      64'(bcd),      64'd0);
    chk("rst_sign",     64'(sign),     64'd0);
    chk("rst_digit_en", 64'(digit_en), 64'd1);
    chk("rst_done",     64'(done),     64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 9; i++) begin
      run_conv(vecs[i].cnt, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_bcd", i),  64'(bcd),      64'(vecs[i].exp_bcd));
      chk($sformatf("vec%0d_sign", i), 64'(sign),     64'(vecs[i].exp_sign));
      chk($sformatf("vec%0d_en", i),   64'(digit_en), 64'(vecs[i].exp_en));
      chk($sformatf("vec%0d_ready_at_done", i), 64'(in_ready), 64'd1);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
      chk($sformatf("vec%0d_held_bcd", i),   64'(bcd),  64'(vecs[i].exp_bcd));
    end

    // Continuous in_valid with count changing every cycle
    last_acc    = -1;
    accepts     = 0;
    spacing_bad = 0;
    ready_bad   = 0;
    in_valid    = 1'b1;
    for (int cyc = 0; cyc < 102; cyc++) begin
      if (done) begin
        if (q.size() > 0) begin
          v = q.pop_front();
          chk($sformatf("hs_bcd_c%0d", cyc),  64'(bcd),  64'(model_bcd(v)));
          chk($sformatf("hs_sign_c%0d", cyc), 64'(sign), 64'(v[31]));
        end else begin
          chk("hs_unexpected_done", 64'd1, 64'd0);
        end
      end
      if (busy === in_ready) ready_bad++;
      count = 32'(cyc * 1000003) - 32'd50000000;
      if (in_ready) begin
        if (last_acc >= 0 && (cyc - last_acc) != 33) spacing_bad++;
        last_acc = cyc;
        q.push_back(count);
        accepts++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    drained = 0;
    for (int k = 0; k < 40 && q.size() > 0; k++) begin
      if (done) begin
        v = q.pop_front();
        chk("hs_last_bcd",  64'(bcd),  64'(model_bcd(v)));
        chk("hs_last_sign", 64'(sign), 64'(v[31]));
        drained = 1;
      end else begin
        @(negedge clk);
      end
    end
    chk("hs_drained",     64'(drained),     64'd1);
    chk("hs_accepts",     64'(accepts),     64'd4);
    chk("hs_spacing",     64'(spacing_bad), 64'd0);
    chk("hs_busy_ready",  64'(ready_bad),   64'd0);

    // Reset in the middle of a conversion discards it
    run_conv(32'd999, "pre999");
    chk("pre999_bcd", 64'(bcd), 64'h999);
    @(negedge clk);
    count = 32'd555;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_bcd",      64'(bcd),      64'd0);
    chk("mid_rst_sign",     64'(sign),     64'd0);
    chk("mid_rst_digit_en", 64'(digit_en), 64'd1);
    chk("mid_rst_done",     64'(done),     64'd0);
    chk("mid_rst_busy",     64'(busy),     64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("mid_rst_no_done", 64'(done_seen), 64'd0);
    chk("mid_rst_idle",    64'(in_ready),  64'd1);
    run_conv(32'd7, "post7");
    chk("post7_bcd",  64'(bcd),      64'd7);
    chk("post7_sign", 64'(sign),     64'd0);
    chk("post7_en",   64'(digit_en), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rot_count_bcd
